hci_mem_responder: RTL and testbench

Memory-side terminator for the HCI memory protocol: accepts requests on the slave side of an `hci_mem_intf` link and serves them from an internal word-addressed array with byte enables. Every granted request returns a response after a configurable fixed latency. Programmable wait states exercise requester grant handling. Sits at the far end of HCI interconnect chains as a TCDM bank model for subsystem benches, or as a small scratchpad.

---
 rtl/hci_mem_responder_pkg.sv | 15 +
 rtl/hci_mem_responder_if.sv | 41 ++++
 rtl/hci_mem_responder_pipe.sv | 39 +++
 rtl/hci_mem_responder.sv | 123 ++++++++++++
 tb/tb_hci_mem_responder.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/hci_mem_responder_pkg.sv
// hci_package: shared types and limits for the HCI memory responder.
//   hci_mem_responder_state_t : grant FSM state (IDLE, WAIT)
//   HCI_MEM_RESP_MAX_LATENCY  : largest supported response latency
//   HCI_MEM_RESP_MAX_WAIT     : largest supported wait-state count
package hci_package;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } hci_mem_responder_state_t;

    localparam int HCI_MEM_RESP_MAX_LATENCY = 4;
    localparam int HCI_MEM_RESP_MAX_WAIT    = 15;

endpackage

// File: rtl/hci_mem_responder_if.sv
// hci_mem_intf: HCI memory link between a requester (master) and a memory
// (slave).
//
// Handshake: the master raises req with a stable payload (add, wen, data,
// be, id, user) and holds it until the slave grants. A transfer happens on
// every rising edge where req & gnt are both high. Responses (r_*) carry
// no backpressure: r_valid is a single-cycle pulse per transfer and the
// master must accept it.
//
// Fields: req/gnt handshake, add byte address, wen (1 = read, 0 = write),
// data write data, be byte enables, id/user sideband echoed on r_id/r_user,
// r_data read data (0 for writes), r_valid response strobe.
interface hci_mem_intf #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32,
    parameter int unsigned IW = 8,
    parameter int unsigned UW = 1
);
    logic              req;
    logic              gnt;
    logic [AW-1:0]     add;
    logic              wen;
    logic [DW-1:0]     data;
    logic [DW/8-1:0]   be;
    logic [IW-1:0]     id;
    logic [UW-1:0]     user;
    logic [DW-1:0]     r_data;
    logic              r_valid;
    logic [IW-1:0]     r_id;
    logic [UW-1:0]     r_user;

    modport master (
        output req, add, wen, data, be, id, user,
        input  gnt, r_data, r_valid, r_id, r_user
    );

    modport slave (
        input  req, add, wen, data, be, id, user,
        output gnt, r_data, r_valid, r_id, r_user
    );
endinterface

// File: rtl/hci_mem_responder_pipe.sv
// hci_mem_responder_pipe: LATENCY-deep response shift register.
//   clk_i   clock
//   clr_i   synchronous clear; drops every stage
//   valid_i stage-0 valid
//   data_i  stage-0 payload
//   valid_o last-stage valid
//   data_o  last-stage payload, forced to 0 whenever the stage is invalid
module hci_mem_responder_pipe #(
    parameter int LATENCY = 1,
    parameter int W       = 1
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);
    logic [LATENCY-1:0] vld;
    logic [W-1:0]       dat [LATENCY];

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            vld <= '0;
            for (int i = 0; i < LATENCY; i++) dat[i] <= '0;
        end else begin
            vld[0] <= valid_i;
            // Payload is zeroed on entry so invalid stages always read 0.
            dat[0] <= valid_i ? data_i : '0;
            for (int i = 1; i < LATENCY; i++) begin
                vld[i] <= vld[i-1];
                dat[i] <= dat[i-1];
            end
        end
    end

    assign valid_o = vld[LATENCY-1];
    assign data_o  = dat[LATENCY-1];
endmodule

// File: rtl/hci_mem_responder.sv
// hci_mem_responder: HCI memory-side terminator backed by a word array with
// byte enables. Each granted request returns one response LATENCY cycles
// later; WAIT_CYCLES stall cycles precede every grant.
//   clk_i       clock, rising edge
//   rst_i       synchronous active-high reset (array contents are kept)
//   bus         hci_mem_intf slave side
//   dbg_state_o grant FSM state
//   dbg_cnt_o   grant FSM wait counter
module hci_mem_responder
    import hci_package::*;
#(
    parameter int unsigned DW          = 32,
    parameter int unsigned AW          = 32,
    parameter int unsigned IW          = 8,
    parameter int unsigned UW          = 1,
    parameter int unsigned NB_WORDS    = 1024,
    parameter int          LATENCY     = 1,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    hci_mem_intf.slave               bus,
    output hci_mem_responder_state_t dbg_state_o,
    output logic [3:0]               dbg_cnt_o
);
    localparam int unsigned OFFW   = $clog2(DW / 8);
    localparam int unsigned IDXW   = $clog2(NB_WORDS);
    localparam int unsigned NBYTES = DW / 8;
    localparam int unsigned RW     = DW + IW + UW;
    localparam logic [3:0]  WAIT_INIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    if (LATENCY < 1 || LATENCY > HCI_MEM_RESP_MAX_LATENCY) begin : g_bad_latency
        $error("hci_mem_responder: LATENCY out of range");
    end
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > HCI_MEM_RESP_MAX_WAIT) begin : g_bad_wait
        $error("hci_mem_responder: WAIT_CYCLES out of range");
    end
    if (NB_WORDS < 2 || (NB_WORDS & (NB_WORDS - 1)) != 0) begin : g_bad_depth
        $error("hci_mem_responder: NB_WORDS must be a power of two");
    end

    hci_mem_responder_state_t state;
    logic [3:0]               cnt;
    logic                     hs;
    logic [IDXW-1:0]          idx;
    logic [DW-1:0]            mem [NB_WORDS];
    logic [DW-1:0]            rd_word;
    logic                     rsp_valid;
    logic [RW-1:0]            rsp_data;
    logic                     addr_unused;

    // Only the word-index field of the address matters; offset and upper
    // bits are deliberately dropped so addresses alias modulo NB_WORDS.
    assign idx         = bus.add[OFFW +: IDXW];
    assign addr_unused = ^bus.add;

    // Grant follows req in the same cycle once the wait has expired; with
    // no wait states the FSM is bypassed entirely.
    assign bus.gnt = !rst_i && bus.req &&
                     ((WAIT_CYCLES == 0) || (state == WAIT && cnt == 4'd0));
    assign hs      = bus.req && bus.gnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else if (WAIT_CYCLES != 0) begin
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        state <= WAIT;
                        cnt   <= WAIT_INIT;
                    end
                end
                WAIT: begin
                    if (!bus.req) begin
                        // Requester withdrew: abandon without a response.
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        // Granted this cycle; the next request pays in full.
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    // Array is intentionally not reset so contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (hs && !bus.wen) begin
            for (int k = 0; k < NBYTES; k++) begin
                if (bus.be[k]) mem[idx][8*k +: 8] <= bus.data[8*k +: 8];
            end
        end
    end

    assign rd_word = (hs && bus.wen) ? mem[idx] : '0;

    hci_mem_responder_pipe #(
        .LATENCY (LATENCY),
        .W       (RW)
    ) u_pipe (
        .clk_i   (clk_i),
        .clr_i   (rst_i),
        .valid_i (hs),
        .data_i  ({rd_word, bus.id, bus.user}),
        .valid_o (rsp_valid),
        .data_o  (rsp_data)
    );

    assign bus.r_valid                       = rsp_valid;
    assign {bus.r_data, bus.r_id, bus.r_user} = rsp_data;

    assign dbg_state_o = state;
    assign dbg_cnt_o   = cnt;
endmodule

// File: tb/tb_hci_mem_responder.sv
module tb_hci_mem_responder;
    import hci_package::*;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int IW = 8;
    localparam int UW = 1;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    hci_mem_intf #(.DW(DW), .AW(AW), .IW(IW), .UW(UW)) ifa ();
    hci_mem_intf #(.DW(DW), .AW(AW), .IW(IW), .UW(UW)) ifb ();
    hci_mem_intf #(.DW(DW), .AW(AW), .IW(IW), .UW(UW)) ifc ();
    hci_mem_intf #(.DW(DW), .AW(AW), .IW(IW), .UW(UW)) ifd ();

    hci_mem_responder_state_t st_a, st_b, st_c, st_d;
    logic [3:0]               cnt_a, cnt_b, cnt_c, cnt_d;

    // a: no wait, latency 1 | b: 3 waits, latency 1
    // c: no wait, latency 4 | d: no wait, latency 3
    hci_mem_responder #(.DW(DW), .AW(AW), .IW(IW), .UW(UW), .NB_WORDS(1024),
                        .LATENCY(1), .WAIT_CYCLES(0)) u_a (
        .clk_i(clk), .rst_i(rst), .bus(ifa.slave), .dbg_state_o(st_a), .dbg_cnt_o(cnt_a));
    hci_mem_responder #(.DW(DW), .AW(AW), .IW(IW), .UW(UW), .NB_WORDS(1024),
                        .LATENCY(1), .WAIT_CYCLES(3)) u_b (
        .clk_i(clk), .rst_i(rst), .bus(ifb.slave), .dbg_state_o(st_b), .dbg_cnt_o(cnt_b));
    hci_mem_responder #(.DW(DW), .AW(AW), .IW(IW), .UW(UW), .NB_WORDS(1024),
                        .LATENCY(4), .WAIT_CYCLES(0)) u_c (
        .clk_i(clk), .rst_i(rst), .bus(ifc.slave), .dbg_state_o(st_c), .dbg_cnt_o(cnt_c));
    hci_mem_responder #(.DW(DW), .AW(AW), .IW(IW), .UW(UW), .NB_WORDS(1024),
                        .LATENCY(3), .WAIT_CYCLES(0)) u_d (
        .clk_i(clk), .rst_i(rst), .bus(ifd.slave), .dbg_state_o(st_d), .dbg_cnt_o(cnt_d));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int which, input logic req, input logic wen,
                         input logic [31:0] add, input logic [31:0] data,
                         input logic [3:0] be, input logic [7:0] id, input logic user);
        case (which)
            0: begin ifa.req = req; ifa.wen = wen; ifa.add = add; ifa.data = data;
                     ifa.be = be; ifa.id = id; ifa.user = user; end
            1: begin ifb.req = req; ifb.wen = wen; ifb.add = add; ifb.data = data;
                     ifb.be = be; ifb.id = id; ifb.user = user; end
            2: begin ifc.req = req; ifc.wen = wen; ifc.add = add; ifc.data = data;
                     ifc.be = be; ifc.id = id; ifc.user = user; end
            default: begin ifd.req = req; ifd.wen = wen; ifd.add = add; ifd.data = data;
                     ifd.be = be; ifd.id = id; ifd.user = user; end
        endcase
    endtask

    task automatic idle(input int which);
        drive(which, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 8'h0, 1'b0);
    endtask

    initial begin
        // ---------------- reset ----------------
        rst = 1'b1;
        for (int w = 0; w < 4; w++) idle(w);
        repeat (3) tick();
        ifa.req = 1'b1;
        #1;
        check_eq("gnt_in_reset", ifa.gnt, 0);
        check_eq("rst_r_valid_a", ifa.r_valid, 0);
        check_eq("rst_r_data_a", ifa.r_data, 0);
        check_eq("rst_r_id_a", ifa.r_id, 0);
        check_eq("rst_r_user_a", ifa.r_user, 0);
        check_eq("rst_r_valid_c", ifc.r_valid, 0);
        check_eq("rst_state_b", st_b, IDLE);
        check_eq("rst_cnt_b", cnt_b, 0);
        ifa.req = 1'b0;
        tick();
        rst = 1'b0;

        // ---------------- write then read, latency 1 ----------------
        tick();
        drive(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 8'd3, 1'b1);
        #1;
        check_eq("wr_gnt_comb", ifa.gnt, 1);
        tick();
        check_eq("wr_r_valid", ifa.r_valid, 1);
        check_eq("wr_r_id", ifa.r_id, 3);
        check_eq("wr_r_data", ifa.r_data, 0);
        check_eq("wr_r_user", ifa.r_user, 1);
        drive(0, 1'b1, 1'b1, 32'h10, 32'h0, 4'h0, 8'd4, 1'b0);
        tick();
        check_eq("rd_r_valid", ifa.r_valid, 1);
        check_eq("rd_r_id", ifa.r_id, 4);
        check_eq("rd_r_data", ifa.r_data, 32'hDEADBEEF);
        check_eq("rd_r_user", ifa.r_user, 0);
        idle(0);
        tick();
        check_eq("idle_r_valid", ifa.r_valid, 0);
        check_eq("idle_r_data", ifa.r_data, 0);
        check_eq("idle_r_id", ifa.r_id, 0);

        // ---------------- byte enables ----------------
        drive(0, 1'b1, 1'b0, 32'h20, 32'h11223344, 4'hF, 8'd5, 1'b0);
        tick();
        drive(0, 1'b1, 1'b0, 32'h20, 32'hAABBCCDD, 4'h5, 8'd6, 1'b0);
        tick();
        drive(0, 1'b1, 1'b0, 32'h20, 32'hFFFFFFFF, 4'h0, 8'd7, 1'b0);
        tick();
        check_eq("be0_r_valid", ifa.r_valid, 1);
        check_eq("be0_r_id", ifa.r_id, 7);
        check_eq("be0_r_data", ifa.r_data, 0);
        drive(0, 1'b1, 1'b1, 32'h22, 32'h0, 4'h0, 8'd8, 1'b0);
        tick();
        check_eq("be_merge_data", ifa.r_data, 32'h11BB33DD);
        check_eq("be_merge_id", ifa.r_id, 8);

        // ---------------- address wrap ----------------
        drive(0, 1'b1, 1'b0, 32'h1000, 32'hCAFEF00D, 4'hF, 8'd9, 1'b0);
        tick();
        drive(0, 1'b1, 1'b1, 32'h3, 32'h0, 4'h0, 8'd10, 1'b0);
        tick();
        check_eq("wrap_r_data", ifa.r_data, 32'hCAFEF00D);
        check_eq("wrap_r_id", ifa.r_id, 10);
        idle(0);
        tick();

        // ---------------- wait states = 3 ----------------
        for (int c = 0; c <= 8; c++) begin
            if (c == 0) drive(1, 1'b1, 1'b1, 32'h0, 32'h0, 4'h0, 8'd1, 1'b0);
            if (c == 4) drive(1, 1'b1, 1'b1, 32'h4, 32'h0, 4'h0, 8'd2, 1'b0);
            if (c == 8) idle(1);
            #1;
            check_eq($sformatf("w3_gnt_c%0d", c), ifb.gnt, (c == 3 || c == 7) ? 1 : 0);
            check_eq($sformatf("w3_r_valid_c%0d", c), ifb.r_valid, (c == 4 || c == 8) ? 1 : 0);
            check_eq($sformatf("w3_r_id_c%0d", c), ifb.r_id, (c == 4) ? 1 : (c == 8) ? 2 : 0);
            check_eq($sformatf("w3_state_c%0d", c), st_b,
                     ((c >= 1 && c <= 3) || (c >= 5 && c <= 7)) ? WAIT : IDLE);
            check_eq($sformatf("w3_cnt_c%0d", c), cnt_b,
                     (c == 1 || c == 5) ? 2 : (c == 2 || c == 6) ? 1 : 0);
            tick();
        end

        // ---------------- latency 4, back-to-back ----------------
        for (int c = 0; c <= 12; c++) begin
            if (c < 8) drive(2, 1'b1, 1'b1, 32'(c * 4), 32'h0, 4'h0, 8'(c), 1'b0);
            else       idle(2);
            #1;
            check_eq($sformatf("l4_r_valid_c%0d", c), ifc.r_valid, (c >= 4 && c <= 11) ? 1 : 0);
            check_eq($sformatf("l4_r_id_c%0d", c), ifc.r_id, (c >= 4 && c <= 11) ? c - 4 : 0);
            tick();
        end

        // ---------------- reset kills in-flight response, array survives ----------------
        drive(3, 1'b1, 1'b0, 32'h8, 32'h5A5A1234, 4'hF, 8'd1, 1'b0);
        tick();
        idle(3);
        repeat (4) tick();
        drive(3, 1'b1, 1'b1, 32'h8, 32'h0, 4'h0, 8'd9, 1'b0);
        tick();
        idle(3);
        rst = 1'b1;
        #1;
        check_eq("rstmid_r_valid_pre", ifd.r_valid, 0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_eq($sformatf("rstmid_dropped_k%0d", k), ifd.r_valid, 0);
            tick();
        end
        drive(3, 1'b1, 1'b1, 32'h8, 32'h0, 4'h0, 8'd10, 1'b0);
        tick();
        idle(3);
        for (int k = 1; k <= 4; k++) begin
            check_eq($sformatf("postrst_r_valid_k%0d", k), ifd.r_valid, (k == 3) ? 1 : 0);
            check_eq($sformatf("postrst_r_data_k%0d", k), ifd.r_data, (k == 3) ? 32'h5A5A1234 : 0);
            tick();
        end
        drive(0, 1'b1, 1'b1, 32'h20, 32'h0, 4'h0, 8'd11, 1'b0);
        tick();
        check_eq("postrst_a_data", ifa.r_data, 32'h11BB33DD);
        idle(0);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
